// File: rtl/datapath.sv
// Datapath for the K&S processor: PC, IR, four-entry register file, ALU and flags register.
// It executes the control word from control_unit and drives the single-port RAM address and write data.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BNZERO,
    I_BNNEG,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_HALT
  } decoded_instruction_type;
endpackage

module datapath
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] reg_q [4];
  logic [DATA_W-1:0] reg_d [4];
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              uovf_q, uovf_d;
  logic              sovf_q, sovf_d;

  decoded_instruction_type instr;

  logic [1:0]        mem_reg_idx;
  logic [1:0]        alu_dst_idx;
  logic [1:0]        alu_a_idx;
  logic [1:0]        alu_b_idx;
  logic [1:0]        mov_dst_idx;
  logic [1:0]        mov_src_idx;
  logic [ADDR_W-1:0] ir_addr;

  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [DATA_W:0]   sum_ext, diff_ext;
  logic              alu_zero, alu_neg, alu_uovf, alu_sovf;
  logic [1:0]        wr_idx;
  logic [DATA_W-1:0] wr_data;

  logic unused_ir_bit7;
  assign unused_ir_bit7 = ir_q[7];

  // Instruction decode from the opcode byte
  always_comb begin
    instr = I_NOP;
    case (ir_q[15:8])
      8'h00:   instr = I_NOP;
      8'h01:   instr = I_BRANCH;
      8'h02:   instr = I_BZERO;
      8'h03:   instr = I_BNEG;
      8'h04:   instr = I_BNZERO;
      8'h05:   instr = I_BNNEG;
      8'h81:   instr = I_LOAD;
      8'h82:   instr = I_STORE;
      8'h91:   instr = I_MOVE;
      8'hA1:   instr = I_ADD;
      8'hA2:   instr = I_SUB;
      8'hA3:   instr = I_AND;
      8'hA4:   instr = I_OR;
      8'hFF:   instr = I_HALT;
      default: instr = I_NOP;
    endcase
  end

  assign decoded_instruction = instr;

  assign mem_reg_idx = ir_q[6:5];
  assign alu_dst_idx = ir_q[5:4];
  assign alu_a_idx   = ir_q[3:2];
  assign alu_b_idx   = ir_q[1:0];
  assign mov_dst_idx = ir_q[3:2];
  assign mov_src_idx = ir_q[1:0];
  assign ir_addr     = ir_q[ADDR_W-1:0];

  // MOVE reuses the ALU: source on A, zero on B, so OR passes it through
  always_comb begin
    alu_a = reg_q[alu_a_idx];
    alu_b = reg_q[alu_b_idx];
    if (instr == I_MOVE) begin
      alu_a = reg_q[mov_src_idx];
      alu_b = '0;
    end
  end

  assign sum_ext  = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff_ext = {1'b0, alu_a} - {1'b0, alu_b};

  always_comb begin
    alu_res  = '0;
    alu_uovf = 1'b0;
    alu_sovf = 1'b0;
    case (operation)
      OP_OR: begin
        alu_res = alu_a | alu_b;
      end
      OP_ADD: begin
        alu_res  = sum_ext[DATA_W-1:0];
        alu_uovf = sum_ext[DATA_W];
        alu_sovf = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                   (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res  = diff_ext[DATA_W-1:0];
        alu_uovf = diff_ext[DATA_W];
        alu_sovf = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                   (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_AND: begin
        alu_res = alu_a & alu_b;
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  assign alu_zero = (alu_res == '0);
  assign alu_neg  = alu_res[DATA_W-1];

  always_comb begin
    if (c_sel) begin
      wr_idx = mem_reg_idx;
    end else if (instr == I_MOVE) begin
      wr_idx = mov_dst_idx;
    end else begin
      wr_idx = alu_dst_idx;
    end
  end

  assign wr_data = c_sel ? data_in : alu_res;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      reg_d[i] = reg_q[i];
    end
    if (write_reg_enable) begin
      reg_d[wr_idx] = wr_data;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_enable) begin
      pc_d = branch ? ir_addr : pc_q + ADDR_W'(1);
    end
  end

  assign ir_d = ir_enable ? data_in : ir_q;

  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    uovf_d = uovf_q;
    sovf_d = sovf_q;
    if (flags_reg_enable) begin
      zero_d = alu_zero;
      neg_d  = alu_neg;
      uovf_d = alu_uovf;
      sovf_d = alu_sovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      uovf_q <= 1'b0;
      sovf_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        reg_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      uovf_q <= uovf_d;
      sovf_q <= sovf_d;
      for (int i = 0; i < 4; i++) begin
        reg_q[i] <= reg_d[i];
      end
    end
  end

  assign zero_op           = zero_q;
  assign neg_op            = neg_q;
  assign unsigned_overflow = uovf_q;
  assign signed_overflow   = sovf_q;

  assign ram_addr = addr_sel ? pc_q : ir_addr;
  assign data_out = reg_q[mem_reg_idx];

endmodule

// File: tb/tb_datapath.sv
// Testbench for datapath: table-driven ALU and decode vectors plus hand-written multi-cycle sequences.
module tb_datapath;
  import k_and_s_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    write_reg_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    flags_reg_enable;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic [4:0]              ram_addr;
  logic [15:0]             data_out;
  logic [15:0]             data_in;

  int checks = 0;
  int errors = 0;

  datapath #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .write_reg_enable    (write_reg_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .flags_reg_enable    (flags_reg_enable),
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .ram_addr            (ram_addr),
    .data_out            (data_out),
    .data_in             (data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ir;
    logic [1:0]  op;
    logic [15:0] exp_r1;
    logic        z;
    logic        n;
    logic        u;
    logic        s;
  } alu_vec_t;

  typedef struct {
    logic [7:0]              opc;
    decoded_instruction_type exp;
  } dec_vec_t;

  alu_vec_t alu_vecs[8];
  dec_vec_t dec_vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [15:0] v);
    data_in   = v;
    ir_enable = 1'b1;
    tick();
    ir_enable = 1'b0;
  endtask

  task automatic load_reg(input logic [1:0] r, input logic [15:0] v);
    set_ir(16'h8100 | (16'(r) << 5));
    data_in          = v;
    c_sel            = 1'b1;
    write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
    c_sel            = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic z, input logic n,
                             input logic u, input logic s);
    check({tag, " zero"}, 32'(zero_op), 32'(z));
    check({tag, " neg"},  32'(neg_op), 32'(n));
    check({tag, " uovf"}, 32'(unsigned_overflow), 32'(u));
    check({tag, " sovf"}, 32'(signed_overflow), 32'(s));
  endtask

  initial begin
    alu_vecs[0] = '{16'h7FFF, 16'h0001, 16'hA11B, 2'b01, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    alu_vecs[1] = '{16'h1234, 16'h1234, 16'hA21B, 2'b10, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    alu_vecs[2] = '{16'h0000, 16'h0001, 16'hA21B, 2'b10, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    alu_vecs[3] = '{16'hFFFF, 16'h0001, 16'hA11B, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    alu_vecs[4] = '{16'h0F0F, 16'hF000, 16'hA41B, 2'b00, 16'hFF0F, 1'b0, 1'b1, 1'b0, 1'b0};
    alu_vecs[5] = '{16'h0F0F, 16'hF0F0, 16'hA31B, 2'b11, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    alu_vecs[6] = '{16'h8000, 16'h0001, 16'hA21B, 2'b10, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    alu_vecs[7] = '{16'h8000, 16'h8000, 16'hA11B, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};

    dec_vecs[0]  = '{8'h00, I_NOP};
    dec_vecs[1]  = '{8'h01, I_BRANCH};
    dec_vecs[2]  = '{8'h02, I_BZERO};
    dec_vecs[3]  = '{8'h03, I_BNEG};
    dec_vecs[4]  = '{8'h04, I_BNZERO};
    dec_vecs[5]  = '{8'h05, I_BNNEG};
    dec_vecs[6]  = '{8'h81, I_LOAD};
    dec_vecs[7]  = '{8'h82, I_STORE};
    dec_vecs[8]  = '{8'h91, I_MOVE};
    dec_vecs[9]  = '{8'hA1, I_ADD};
    dec_vecs[10] = '{8'hA2, I_SUB};
    dec_vecs[11] = '{8'hA3, I_AND};
    dec_vecs[12] = '{8'hA4, I_OR};
    dec_vecs[13] = '{8'hFF, I_HALT};
    dec_vecs[14] = '{8'h12, I_NOP};
    dec_vecs[15] = '{8'h06, I_NOP};
    dec_vecs[16] = '{8'h80, I_NOP};
    dec_vecs[17] = '{8'hA5, I_NOP};

    rst = 1'b1;
    branch = 1'b0;
    pc_enable = 1'b0;
    ir_enable = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel = 1'b1;
    c_sel = 1'b0;
    operation = 2'b00;
    flags_reg_enable = 1'b0;
    data_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset decode", 32'(decoded_instruction), 32'(I_NOP));
    check("reset ram_addr", 32'(ram_addr), 32'h0);
    check("reset data_out", 32'(data_out), 32'h0);
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Decode table
    for (int i = 0; i < 18; i++) begin
      set_ir({dec_vecs[i].opc, 8'h00});
      check($sformatf("decode %02h", dec_vecs[i].opc), 32'(decoded_instruction),
            32'(dec_vecs[i].exp));
    end
    set_ir(16'hA11B);
    check("decode A11B", 32'(decoded_instruction), 32'(I_ADD));
    set_ir(16'h1234);
    check("decode 1234", 32'(decoded_instruction), 32'(I_NOP));

    // ALU table: R1 = R2 op R3, result read back through the STORE port
    for (int i = 0; i < 8; i++) begin
      load_reg(2'd2, alu_vecs[i].a);
      load_reg(2'd3, alu_vecs[i].b);
      set_ir(alu_vecs[i].ir);
      operation        = alu_vecs[i].op;
      write_reg_enable = 1'b1;
      flags_reg_enable = 1'b1;
      tick();
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      set_ir(16'h8220);
      check($sformatf("alu%0d r1", i), 32'(data_out), 32'(alu_vecs[i].exp_r1));
      check_flags($sformatf("alu%0d", i), alu_vecs[i].z, alu_vecs[i].n,
                  alu_vecs[i].u, alu_vecs[i].s);
    end

    // Flags hold while the ALU computes something else without flags_reg_enable
    load_reg(2'd2, 16'h0001);
    load_reg(2'd3, 16'h0001);
    set_ir(16'hA11B);
    operation = 2'b01;
    tick();
    check_flags("hold", 1'b1, 1'b0, 1'b1, 1'b1);

    // Destination equal to both sources uses pre-edge value
    load_reg(2'd1, 16'h0003);
    set_ir(16'hA115);
    operation        = 2'b01;
    write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
    set_ir(16'h8220);
    check("r1 doubled", 32'(data_out), 32'h0006);

    // MOVE R1 <- R2
    load_reg(2'd2, 16'hC0DE);
    set_ir(16'h9106);
    operation        = 2'b00;
    write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
    set_ir(16'h8220);
    check("move r1", 32'(data_out), 32'hC0DE);

    // LOAD/STORE addressing
    addr_sel = 1'b0;
    set_ir(16'h8145);
    check("load ram_addr", 32'(ram_addr), 32'h05);
    data_in          = 16'hBEEF;
    c_sel            = 1'b1;
    write_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
    c_sel            = 1'b0;
    set_ir(16'h8245);
    check("store data_out", 32'(data_out), 32'hBEEF);
    check("store ram_addr", 32'(ram_addr), 32'h05);

    // PC branch, wrap and hold
    addr_sel = 1'b1;
    set_ir(16'h011F);
    branch    = 1'b1;
    pc_enable = 1'b1;
    tick();
    check("pc branch 31", 32'(ram_addr), 32'h1F);
    branch = 1'b0;
    tick();
    check("pc wrap", 32'(ram_addr), 32'h00);
    tick();
    pc_enable = 1'b0;
    check("pc inc", 32'(ram_addr), 32'h01);
    set_ir(16'h0112);
    branch    = 1'b1;
    pc_enable = 1'b1;
    tick();
    pc_enable = 1'b0;
    branch    = 1'b0;
    check("pc branch 12", 32'(ram_addr), 32'h12);
    tick();
    check("pc hold", 32'(ram_addr), 32'h12);

    // IR load and PC branch on the same edge: branch uses the old IR
    set_ir(16'h0103);
    data_in   = 16'h0109;
    ir_enable = 1'b1;
    pc_enable = 1'b1;
    branch    = 1'b1;
    tick();
    ir_enable = 1'b0;
    check("same-edge pc", 32'(ram_addr), 32'h03);
    check("same-edge ir", 32'(decoded_instruction), 32'(I_BRANCH));
    tick();
    pc_enable = 1'b0;
    branch    = 1'b0;
    check("same-edge next pc", 32'(ram_addr), 32'h09);

    // Asynchronous reset mid-run with PC=7, R1=5 and flags set
    set_ir(16'h0107);
    branch    = 1'b1;
    pc_enable = 1'b1;
    tick();
    branch    = 1'b0;
    pc_enable = 1'b0;
    load_reg(2'd1, 16'h0005);
    load_reg(2'd2, 16'h7FFF);
    load_reg(2'd3, 16'h0001);
    set_ir(16'hA11B);
    operation        = 2'b01;
    flags_reg_enable = 1'b1;
    tick();
    flags_reg_enable = 1'b0;
    set_ir(16'h8220);
    check("pre-rst pc", 32'(ram_addr), 32'h07);
    check("pre-rst r1", 32'(data_out), 32'h0005);
    check("pre-rst neg", 32'(neg_op), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst ram_addr", 32'(ram_addr), 32'h00);
    check("rst decode", 32'(decoded_instruction), 32'(I_NOP));
    check("rst data_out", 32'(data_out), 32'h0000);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    set_ir(16'h8220);
    check("post-rst r1", 32'(data_out), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
